key_debounce_array: RTL and testbench



---
 rtl/key_debounce_array_if.sv | 26 ++
 rtl/key_debounce_array.sv | 165 ++++++++++++++++
 tb/tb_key_debounce_array.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_array_if.sv
// Pad-side bundle of the key debounce array: raw pad levels in, debounced level and pulses out.
interface key_debounce_array_if #(
  parameter int N_KEYS = 8
);
  logic [N_KEYS-1:0] raw_keys;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_change;

  modport master (
    output raw_keys,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_change
  );

  modport slave (
    input  raw_keys,
    output key_level,
    output key_press,
    output key_release,
    output key_change
  );
endinterface

// File: rtl/key_debounce_array.sv
// Multi-channel key front end: 2-flop synchroniser, counter debouncer, registered press/release/change pulses.
// Optional hold-to-repeat per REPEAT_MASK channel when KEY_AUTOREPEAT_EN is defined.
//   state   | meaning
//   RP_IDLE | key released, no repeat timing
//   RP_HOLD | key held, rpc counts toward next repeat pulse
module key_debounce_array #(
  parameter int          N_KEYS          = 8,
  parameter int          DEBOUNCE_CYCLES = 2500000,
  parameter int          CNT_W           = 22,
  parameter bit          ACTIVE_LEVEL    = 1'b1,
  parameter logic [31:0] REPEAT_MASK     = 32'h0000_000B,
  parameter int          REPEAT_DELAY    = 12500000,
  parameter int          REPEAT_PERIOD   = 2500000
) (
  input logic              CLK_25M,
  input logic              RST,
  key_debounce_array_if.slave kif
);

  // Raw level that means "released"; the synchroniser resets here so reset looks like all keys up.
  localparam logic [N_KEYS-1:0] IDLE_RAW = {N_KEYS{~ACTIVE_LEVEL}};
  localparam logic [CNT_W-1:0]  DBC_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] key_s;

  always_ff @(posedge CLK_25M or posedge RST) begin
    if (RST) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
    end else begin
      sync1_q <= kif.raw_keys;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = sync2_q ^ IDLE_RAW;

`ifdef KEY_AUTOREPEAT_EN
  typedef enum logic {
    RP_IDLE = 1'b0,
    RP_HOLD = 1'b1
  } rp_state_t;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_MASK, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [CNT_W-1:0] dbc_q;
    logic [CNT_W-1:0] dbc_d;
    logic             level_q;
    logic             level_d;
    logic             accept;
    logic             rep_fire;
    logic             press_q;
    logic             release_q;
    logic             change_q;

    // Any sample matching the current level restarts the count: no partial credit for glitches.
    always_comb begin
      dbc_d   = dbc_q;
      level_d = level_q;
      accept  = 1'b0;
      if (key_s[i] == level_q) begin
        dbc_d = '0;
      end else if (dbc_q == DBC_LAST) begin
        level_d = key_s[i];
        dbc_d   = '0;
        accept  = 1'b1;
      end else begin
        dbc_d = dbc_q + 1'b1;
      end
    end

    always_ff @(posedge CLK_25M or posedge RST) begin
      if (RST) begin
        dbc_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        change_q  <= 1'b0;
      end else begin
        dbc_q     <= dbc_d;
        level_q   <= level_d;
        press_q   <= (accept & level_d) | rep_fire;
        release_q <= accept & ~level_d;
        change_q  <= accept;
      end
    end

`ifdef KEY_AUTOREPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rep
      rp_state_t        rp_q;
      rp_state_t        rp_d;
      logic [CNT_W-1:0] rpc_q;
      logic [CNT_W-1:0] rpc_d;
      logic             first_q;
      logic             first_d;
      logic [CNT_W-1:0] rpc_last;

      // The first repeat waits the longer hold delay, later ones use the period.
      assign rpc_last = first_q ? DLY_LAST : PER_LAST;

      always_comb begin
        rp_d     = rp_q;
        rpc_d    = rpc_q;
        first_d  = first_q;
        rep_fire = 1'b0;
        case (rp_q)
          RP_IDLE: begin
            if (accept && level_d) begin
              rp_d    = RP_HOLD;
              rpc_d   = '0;
              first_d = 1'b1;
            end
          end
          RP_HOLD: begin
            if (accept && !level_d) begin
              rp_d  = RP_IDLE;
              rpc_d = '0;
            end else if (rpc_q == rpc_last) begin
              rep_fire = 1'b1;
              rpc_d    = '0;
              first_d  = 1'b0;
            end else begin
              rpc_d = rpc_q + 1'b1;
            end
          end
          default: begin
            rp_d  = RP_IDLE;
            rpc_d = '0;
          end
        endcase
      end

      always_ff @(posedge CLK_25M or posedge RST) begin
        if (RST) begin
          rp_q    <= RP_IDLE;
          rpc_q   <= '0;
          first_q <= 1'b0;
        end else begin
          rp_q    <= rp_d;
          rpc_q   <= rpc_d;
          first_q <= first_d;
        end
      end
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign kif.key_level[i]   = level_q;
    assign kif.key_press[i]   = press_q;
    assign kif.key_release[i] = release_q;
    assign kif.key_change[i]  = change_q;
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Scoreboard bench for key_debounce_array: active-high and active-low instances, hand-computed event tables.
module tb_key_debounce_array;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] c;
    logic [3:0] l;
  } ev_t;

  ev_t        qa[$];
  ev_t        qb[$];
  logic [3:0] lvl_a = 4'b0000;
  logic [3:0] lvl_b = 4'b0000;

  key_debounce_array_if #(.N_KEYS(4)) kif_a ();
  key_debounce_array_if #(.N_KEYS(4)) kif_b ();

  key_debounce_array #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .CNT_W(8), .ACTIVE_LEVEL(1'b1),
    .REPEAT_MASK(32'h1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut_a (
    .CLK_25M(clk), .RST(rst), .kif(kif_a)
  );

  key_debounce_array #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .CNT_W(8), .ACTIVE_LEVEL(1'b0),
    .REPEAT_MASK(32'h0), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut_b (
    .CLK_25M(clk), .RST(rst), .kif(kif_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_a(input int t, input logic [3:0] p, r, c, l);
    ev_t e;
    e.cyc = t; e.p = p; e.r = r; e.c = c; e.l = l;
    qa.push_back(e);
  endtask

  task automatic push_b(input int t, input logic [3:0] p, r, c, l);
    ev_t e;
    e.cyc = t; e.p = p; e.r = r; e.c = c; e.l = l;
    qb.push_back(e);
  endtask

  task automatic mon(input int id, input logic [3:0] p, r, c, l);
    ev_t e;
    int  qsz;
    qsz = (id == 0) ? qa.size() : qb.size();
    if ((p | r | c) != 4'b0000) begin
      n_tests++;
      if (qsz == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse dut%0d cyc=%0d got press=%b release=%b change=%b, expected no pulse",
                 id, cyc, p, r, c);
      end else begin
        if (id == 0) e = qa.pop_front(); else e = qb.pop_front();
        if (e.cyc != cyc || e.p !== p || e.r !== r || e.c !== c || e.l !== l) begin
          n_fail++;
          $display("FAIL event dut%0d got cyc=%0d p=%b r=%b c=%b l=%b, expected cyc=%0d p=%b r=%b c=%b l=%b",
                   id, cyc, p, r, c, l, e.cyc, e.p, e.r, e.c, e.l);
        end
        if (id == 0) lvl_a = e.l; else lvl_b = e.l;
      end
    end else begin
      n_tests++;
      if (l !== ((id == 0) ? lvl_a : lvl_b)) begin
        n_fail++;
        $display("FAIL idle_level dut%0d cyc=%0d got %b, expected %b",
                 id, cyc, l, (id == 0) ? lvl_a : lvl_b);
      end
      if (qsz != 0) begin
        if (id == 0) e = qa[0]; else e = qb[0];
        if (e.cyc <= cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL missing_event dut%0d cyc=%0d got no pulse, expected p=%b r=%b c=%b at cyc=%0d",
                   id, cyc, e.p, e.r, e.c, e.cyc);
          if (id == 0) begin
            e = qa.pop_front(); lvl_a = e.l;
          end else begin
            e = qb.pop_front(); lvl_b = e.l;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, kif_a.key_press, kif_a.key_release, kif_a.key_change, kif_a.key_level);
    mon(1, kif_b.key_press, kif_b.key_release, kif_b.key_change, kif_b.key_level);
  end

  task automatic check_zero(input string name);
    n_tests++;
    if ({kif_a.key_level, kif_a.key_press, kif_a.key_release, kif_a.key_change,
         kif_b.key_level, kif_b.key_press, kif_b.key_release, kif_b.key_change} !== 32'h0) begin
      n_fail++;
      $display("FAIL %s got a: l=%b p=%b r=%b c=%b b: l=%b p=%b r=%b c=%b, expected all zero", name,
               kif_a.key_level, kif_a.key_press, kif_a.key_release, kif_a.key_change,
               kif_b.key_level, kif_b.key_press, kif_b.key_release, kif_b.key_change);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d, expected bench to finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int u;
    rst = 1'b1;
    kif_a.raw_keys = 4'b0000;
    kif_b.raw_keys = 4'b1111;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_zero("first_cycle_after_reset");
    repeat (2) @(negedge clk);

    // single press then release on channel 0
    kif_a.raw_keys[0] = 1'b1;
    push_a(cyc + 6, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
    repeat (7) @(negedge clk);
    kif_a.raw_keys[0] = 1'b0;
    push_a(cyc + 6, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    repeat (8) @(negedge clk);

    // bouncing channel 1, stays held afterwards
    for (int k = 0; k < 4; k++) begin
      kif_a.raw_keys[1] = ~k[0];
      repeat (2) @(negedge clk);
    end
    kif_a.raw_keys[1] = 1'b1;
    push_a(cyc + 6, 4'b0010, 4'b0000, 4'b0010, 4'b0010);
    repeat (8) @(negedge clk);

    // simultaneous press on channels 0 and 3
    kif_a.raw_keys[0] = 1'b1;
    kif_a.raw_keys[3] = 1'b1;
    push_a(cyc + 6, 4'b1001, 4'b0000, 4'b1001, 4'b1011);
    repeat (7) @(negedge clk);
    kif_a.raw_keys[0] = 1'b0;
    kif_a.raw_keys[3] = 1'b0;
    push_a(cyc + 6, 4'b0000, 4'b1001, 4'b1001, 4'b0010);
    repeat (8) @(negedge clk);

    // reset while channel 1 is level 1 and channel 2 is mid-count
    kif_a.raw_keys[2] = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst   = 1'b1;
    lvl_a = 4'b0000;
    lvl_b = 4'b0000;
    #1;
    check_zero("async_reset_clear");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_a(cyc + 6, 4'b0110, 4'b0000, 4'b0110, 4'b0110);
    repeat (7) @(negedge clk);
    kif_a.raw_keys[1] = 1'b0;
    kif_a.raw_keys[2] = 1'b0;
    push_a(cyc + 6, 4'b0000, 4'b0110, 4'b0110, 4'b0000);
    repeat (8) @(negedge clk);

    // active-low instance: press then release, each held 10 cycles
    kif_b.raw_keys[0] = 1'b0;
    push_b(cyc + 6, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
    repeat (10) @(negedge clk);
    kif_b.raw_keys[0] = 1'b1;
    push_b(cyc + 6, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    repeat (10) @(negedge clk);

    // hold channels 0 and 1 for 30 cycles; only channel 0 may repeat
    u = cyc;
    kif_a.raw_keys[1:0] = 2'b11;
    push_a(u + 6, 4'b0011, 4'b0000, 4'b0011, 4'b0011);
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 14; k <= 35; k += 3)
      push_a(u + k, 4'b0001, 4'b0000, 4'b0000, 4'b0011);
`endif
    repeat (30) @(negedge clk);
    kif_a.raw_keys[1:0] = 2'b00;
    push_a(u + 36, 4'b0000, 4'b0011, 4'b0011, 4'b0000);

    for (int k = 0; k < 40 && (qa.size() != 0 || qb.size() != 0); k++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d/%0d pending events, expected 0/0", qa.size(), qb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
